// File: rtl/button_event_classifier.sv
// Classifies a debounced button level into short, long and double press pulses
// and keeps a wrapping 4-bit count of classified events.
module button_event_classifier #(
  parameter int LONG_LIMIT    = 50_000_000,
  parameter int DCLICK_WINDOW = 25_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_debounced,
  output logic       o_short,
  output logic       o_long,
  output logic       o_double,
  output logic [3:0] o_count,
  output logic       o_busy
);

  localparam int MAX_LIMIT = (LONG_LIMIT > DCLICK_WINDOW) ? LONG_LIMIT : DCLICK_WINDOW;
  localparam int CW        = $clog2(MAX_LIMIT);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_LIMIT - 1);
  localparam logic [CW-1:0] DCLICK_LAST = CW'(DCLICK_WINDOW - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          in_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          double_q, double_d;
  logic [3:0]    count_q, count_d;
  logic          busy_q, busy_d;
  logic          rise_s, fall_s, event_s;

  assign rise_s = i_debounced & ~in_q;
  assign fall_s = ~i_debounced & in_q;

  // State and output registers; in_q resets high so a held button yields no rise
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      in_q     <= 1'b1;
      cnt_q    <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      count_q  <= 4'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_q     <= i_debounced;
      cnt_q    <= cnt_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic; release beats the long limit and a new press beats the window timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise_s) state_d = PRESS1;
        else        state_d = IDLE;
      end
      PRESS1: begin
        if (fall_s)                  state_d = WAIT2;
        else if (cnt_q == LONG_LAST) state_d = LONG_HOLD;
        else                         state_d = PRESS1;
      end
      WAIT2: begin
        if (rise_s)                    state_d = PRESS2;
        else if (cnt_q == DCLICK_LAST) state_d = IDLE;
        else                           state_d = WAIT2;
      end
      PRESS2: begin
        if (fall_s) state_d = IDLE;
        else        state_d = PRESS2;
      end
      LONG_HOLD: begin
        if (fall_s) state_d = IDLE;
        else        state_d = LONG_HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Event pulses, cycle counter, event count and busy flag for the next cycle
  always_comb begin
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;
    case (state_q)
      PRESS1: begin
        if (!fall_s && (cnt_q == LONG_LAST)) long_d = 1'b1;
        else                                 long_d = 1'b0;
      end
      WAIT2: begin
        if (!rise_s && (cnt_q == DCLICK_LAST)) short_d = 1'b1;
        else                                   short_d = 1'b0;
      end
      PRESS2: begin
        if (fall_s) double_d = 1'b1;
        else        double_d = 1'b0;
      end
      default: begin
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
      end
    endcase
    event_s = short_d | long_d | double_d;
    count_d = count_q + {3'b000, event_s};
    busy_d  = (state_d != IDLE);
    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_q + CW'(1);
  end

  assign o_short  = short_q;
  assign o_long   = long_q;
  assign o_double = double_q;
  assign o_count  = count_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_button_event_classifier.sv
// Self-checking bench: table-driven press scenarios, exact-timing sequences and
// random levels, all checked against a timestamp-based reference model.
module tb_button_event_classifier;

  localparam int LL = 8;
  localparam int DW = 6;

  logic       clk;
  logic       rst_n;
  logic       deb;
  logic       o_short, o_long, o_double, o_busy;
  logic [3:0] o_count;

  button_event_classifier #(.LONG_LIMIT(LL), .DCLICK_WINDOW(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_debounced(deb),
    .o_short    (o_short),
    .o_long     (o_long),
    .o_double   (o_double),
    .o_count    (o_count),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: phase of the gesture plus timestamps of press and release
  int ph, n, t_press, t_rel, mcount;
  bit prev, m_s, m_l, m_d;
  int acc_s, acc_l, acc_d;

  typedef struct {
    string name;
    int    hold1, gap, hold2;
    int    e_short, e_long, e_double;
  } scen_t;
  scen_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph = 0; n = 0; prev = 1'b1; mcount = 0;
    m_s = 1'b0; m_l = 1'b0; m_d = 1'b0;
  endtask

  task automatic model_step(input bit d);
    bit rise, fall;
    rise = d && !prev;
    fall = !d && prev;
    m_s = 1'b0; m_l = 1'b0; m_d = 1'b0;
    case (ph)
      0: if (rise) begin ph = 1; t_press = n; end
      1: if (fall) begin ph = 2; t_rel = n; end
         else if (n - t_press == LL) begin m_l = 1'b1; ph = 3; end
      2: if (rise) ph = 4;
         else if (n - t_rel == DW) begin m_s = 1'b1; ph = 0; end
      3: if (fall) ph = 0;
      4: if (fall) begin m_d = 1'b1; ph = 0; end
      default: ph = 0;
    endcase
    prev = d;
    n++;
    mcount = (mcount + int'(m_s) + int'(m_l) + int'(m_d)) % 16;
  endtask

  task automatic step(input bit d);
    deb = d;
    @(posedge clk);
    #1;
    model_step(d);
    chk("cycle", {24'd0, o_short, o_long, o_double, o_busy, o_count},
        {24'd0, m_s, m_l, m_d, (ph != 0), 4'(mcount)});
    acc_s += int'(o_short);
    acc_l += int'(o_long);
    acc_d += int'(o_double);
  endtask

  task automatic do_reset(input bit d);
    deb = d;
    rst_n = 1'b0;
    #1;
    chk("reset_async", {27'd0, o_short, o_long, o_double, o_busy, o_count[0]}, 32'd0);
    chk("reset_count", {28'd0, o_count}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_scen(input scen_t s);
    int c0;
    c0 = int'(o_count);
    acc_s = 0; acc_l = 0; acc_d = 0;
    repeat (s.hold1) step(1'b1);
    repeat (s.gap) step(1'b0);
    repeat (s.hold2) step(1'b1);
    repeat (12) step(1'b0);
    chk({s.name, "_short"}, acc_s, s.e_short);
    chk({s.name, "_long"}, acc_l, s.e_long);
    chk({s.name, "_double"}, acc_d, s.e_double);
    chk({s.name, "_count"}, {28'd0, o_count},
        (c0 + s.e_short + s.e_long + s.e_double) % 16);
  endtask

  initial begin
    int idx;
    bit lvl;
    tbl[0] = '{"short",        3, 12,  0, 1, 0, 0};
    tbl[1] = '{"long",        20, 12,  0, 0, 1, 0};
    tbl[2] = '{"double",       2,  3, 12, 0, 0, 1};
    tbl[3] = '{"rel_at_lim",   8, 12,  0, 1, 0, 0};
    tbl[4] = '{"rel_after",    9, 12,  0, 0, 1, 0};
    tbl[5] = '{"rise_at_win",  2,  6,  2, 0, 0, 1};
    tbl[6] = '{"rise_late",    2,  7,  2, 2, 0, 0};
    tbl[7] = '{"long_2nd",     1,  2, 25, 0, 0, 1};

    rst_n = 1'b1;
    deb = 1'b0;
    acc_s = 0; acc_l = 0; acc_d = 0;
    #2;
    do_reset(1'b0);
    repeat (3) step(1'b0);

    foreach (tbl[i]) run_scen(tbl[i]);

    // Exact long-press timing and busy fall on release
    idx = -1;
    step(1'b1);
    for (int j = 1; j < 20; j++) begin
      step(1'b1);
      if (o_long && idx < 0) idx = j;
    end
    chk("long_edge", idx, 8);
    step(1'b0);
    chk("long_busy_fall", {31'd0, o_busy}, 32'd0);
    repeat (3) step(1'b0);

    // Exact short-press timing relative to the release edge
    idx = -1;
    repeat (3) step(1'b1);
    step(1'b0);
    for (int j = 1; j < 10; j++) begin
      step(1'b0);
      if (o_short && idx < 0) idx = j;
    end
    chk("short_edge", idx, 6);

    // Reset mid-PRESS1 and mid-WAIT2: nothing emitted afterwards
    repeat (3) step(1'b1);
    do_reset(1'b1);
    acc_s = 0; acc_l = 0; acc_d = 0;
    repeat (15) step(1'b0);
    repeat (3) step(1'b1);
    repeat (2) step(1'b0);
    do_reset(1'b0);
    repeat (12) step(1'b0);
    chk("reset_no_event", acc_s + acc_l + acc_d, 0);

    // Button held through reset release: no event until release then new press
    do_reset(1'b1);
    acc_s = 0; acc_l = 0; acc_d = 0;
    repeat (15) step(1'b1);
    chk("held_no_event", acc_s + acc_l + acc_d, 0);
    repeat (3) step(1'b0);
    repeat (3) step(1'b1);
    repeat (10) step(1'b0);
    chk("held_then_short", acc_s, 1);

    // Seventeen short presses wrap the count to 1
    do_reset(1'b0);
    repeat (2) step(1'b0);
    acc_s = 0;
    repeat (17) begin
      repeat (2) step(1'b1);
      repeat (8) step(1'b0);
    end
    chk("wrap_shorts", acc_s, 17);
    chk("wrap_count", {28'd0, o_count}, 32'd1);

    // Random level runs with occasional resets
    lvl = 1'b0;
    for (int r = 0; r < 250; r++) begin
      lvl = ~lvl;
      repeat ($urandom_range(1, 14)) step(lvl);
      if ($urandom_range(0, 29) == 0) do_reset(lvl);
    end
    repeat (20) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
